// File: rtl/ble_pkg.sv
// Shared definitions for the Bluefruit control-pad packet parser:
// parser state encoding and the packet byte values it recognises.
package ble_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TYPE,
        BTN,
        STATE,
        CSUM
    } ble_state_t;

    localparam logic [7:0] BLE_START    = 8'h21;
    localparam logic [7:0] BLE_TYPE_BTN = 8'h42;
    localparam logic [7:0] BLE_BTN_MIN  = 8'h31;
    localparam logic [7:0] BLE_BTN_MAX  = 8'h38;
    localparam logic [7:0] BLE_PRESS    = 8'h31;
    localparam logic [7:0] BLE_RELEASE  = 8'h30;

endpackage

// File: rtl/ble_pad_parser.sv
// Parses "!B<btn><state><csum>" pad packets into button events and a held state vector; event one cycle after csum byte.
// No backpressure: every valid byte is consumed; malformed or stalled packets are dropped and counted.
module ble_pad_parser
    import ble_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 742500,
    parameter int ERR_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    output logic [7:0]       btn_state_out,
    output logic             event_valid_out,
    output logic [2:0]       event_btn_out,
    output logic             event_pressed_out,
    output logic [ERR_W-1:0] err_count_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ble_state_t       state, state_nxt;
    logic [7:0]       sum, sum_nxt;
    logic [2:0]       idx, idx_nxt;
    logic             pressed, pressed_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             err;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sum_nxt     = sum;
        idx_nxt     = idx;
        pressed_nxt = pressed;
        accept      = 1'b0;
        err         = 1'b0;
        // Gap counter only runs inside a packet; any consumed byte restarts it.
        cnt_nxt     = (state == IDLE || byte_valid_in) ? '0 : cnt + CNT_W'(1);

        if (byte_valid_in) begin
            case (state)
                IDLE: begin
                    if (byte_in == BLE_START) begin
                        state_nxt = TYPE;
                        sum_nxt   = BLE_START;
                    end
                end
                TYPE: begin
                    if (byte_in == BLE_TYPE_BTN) begin
                        state_nxt = BTN;
                        sum_nxt   = sum + byte_in;
                    end else if (byte_in == BLE_START) begin
                        sum_nxt   = BLE_START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                BTN: begin
                    if (byte_in >= BLE_BTN_MIN && byte_in <= BLE_BTN_MAX) begin
                        state_nxt = STATE;
                        idx_nxt   = 3'(byte_in - BLE_BTN_MIN);
                        sum_nxt   = sum + byte_in;
                    end else begin
                        state_nxt = IDLE;
                        err       = 1'b1;
                    end
                end
                STATE: begin
                    if (byte_in == BLE_PRESS || byte_in == BLE_RELEASE) begin
                        state_nxt   = CSUM;
                        pressed_nxt = byte_in[0];
                        sum_nxt     = sum + byte_in;
                    end else begin
                        state_nxt = IDLE;
                        err       = 1'b1;
                    end
                end
                CSUM: begin
                    state_nxt = IDLE;
                    if (byte_in == ~sum) begin
                        accept = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && cnt == CNT_LAST) begin
            state_nxt = IDLE;
            err       = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum               <= '0;
            idx               <= '0;
            pressed           <= 1'b0;
            cnt               <= '0;
            btn_state_out     <= '0;
            event_valid_out   <= 1'b0;
            event_btn_out     <= '0;
            event_pressed_out <= 1'b0;
            err_count_out     <= '0;
        end else begin
            sum             <= sum_nxt;
            idx             <= idx_nxt;
            pressed         <= pressed_nxt;
            cnt             <= cnt_nxt;
            event_valid_out <= accept;
            if (accept) begin
                event_btn_out      <= idx;
                event_pressed_out  <= pressed;
                btn_state_out[idx] <= pressed;
            end
            if (err && err_count_out != '1) begin
                err_count_out <= err_count_out + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ble_pad_parser.sv
// Bench for ble_pad_parser: directed packet table, corner-case sequences and
// randomized byte streams checked against a packet-level reference model.
module tb_ble_pad_parser;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] btn_state;
    logic       ev;
    logic [2:0] ev_btn;
    logic       ev_pr;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ble_pad_parser #(.TIMEOUT_CYCLES(TO), .ERR_W(8)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid),
        .btn_state_out     (btn_state),
        .event_valid_out   (ev),
        .event_btn_out     (ev_btn),
        .event_pressed_out (ev_pr),
        .err_count_out     (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: buffers the bytes of the packet in progress
    logic [7:0] q[$];
    int         gap;
    logic       m_ev;
    logic [2:0] m_btn;
    logic       m_pr;
    logic [7:0] m_state;
    logic [7:0] m_err;

    task automatic model_reset();
        q.delete();
        gap = 0;
        m_ev = 0; m_btn = 0; m_pr = 0; m_state = 0; m_err = 0;
    endtask

    task automatic model_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        logic [7:0] tot;
        m_ev = 0;
        if (!v) begin
            if (q.size() > 0) begin
                gap++;
                if (gap == TO) begin
                    model_err();
                    gap = 0;
                end
            end
            return;
        end
        gap = 0;
        case (q.size())
            0: if (b == 8'h21) q.push_back(b);
            1: begin
                if (b == 8'h42) q.push_back(b);
                else if (b != 8'h21) q.delete();
            end
            2: if (b >= 8'h31 && b <= 8'h38) q.push_back(b); else model_err();
            3: if (b == 8'h30 || b == 8'h31) q.push_back(b); else model_err();
            default: begin
                tot = q[0] + q[1] + q[2] + q[3];
                if (b == ~tot) begin
                    m_ev  = 1;
                    m_btn = 3'(q[2] - 8'h31);
                    m_pr  = q[3][0];
                    m_state[m_btn] = m_pr;
                    q.delete();
                end else begin
                    model_err();
                end
            end
        endcase
    endtask

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Sample last edge's outputs against the model, then drive the next input.
    task automatic tick(input logic v, input logic [7:0] b);
        @(negedge clk);
        expect_eq("model", {11'd0, ev, ev_btn, ev_pr, btn_state, err_cnt},
                  {11'd0, m_ev, m_btn, m_pr, m_state, m_err});
        byte_in    = b;
        byte_valid = v;
        model_step(v, b);
    endtask

    task automatic send5(input logic [39:0] p);
        for (int i = 0; i < 5; i++) tick(1'b1, p[39-8*i -: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    typedef struct {
        logic [39:0] pkt;
        logic        ev;
        logic [2:0]  btn;
        logic        pr;
        logic [7:0]  st;
        logic [7:0]  err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0] p[5];
        logic [7:0] s;
        int r;

        tbl[0] = '{40'h2142353136, 1'b1, 3'd4, 1'b1, 8'h10, 8'd0};
        tbl[1] = '{40'h2142353037, 1'b1, 3'd4, 1'b0, 8'h00, 8'd0};
        tbl[2] = '{40'h2142313100, 1'b0, 3'd0, 1'b0, 8'h00, 8'd1};
        tbl[3] = '{40'h2142393131, 1'b0, 3'd0, 1'b0, 8'h00, 8'd2};
        tbl[4] = '{40'h2142323231, 1'b0, 3'd0, 1'b0, 8'h00, 8'd3};
        tbl[5] = '{40'h214231313A, 1'b1, 3'd0, 1'b1, 8'h01, 8'd3};
        tbl[6] = '{40'h214231313A, 1'b1, 3'd0, 1'b1, 8'h01, 8'd3};
        tbl[7] = '{40'h214231303B, 1'b1, 3'd0, 1'b0, 8'h00, 8'd3};

        rst = 1'b1; byte_in = 0; byte_valid = 0;
        model_reset();
        #3;
        expect_eq("reset_outputs", {19'd0, ev, ev_btn, ev_pr, btn_state, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            send5(tbl[i].pkt);
            tick(1'b0, 8'h00);
            expect_eq($sformatf("tbl%0d_ev", i), 32'(ev), 32'(tbl[i].ev));
            if (tbl[i].ev) expect_eq($sformatf("tbl%0d_evt", i), {ev_btn, ev_pr}, {tbl[i].btn, tbl[i].pr});
            expect_eq($sformatf("tbl%0d_state", i), 32'(btn_state), 32'(tbl[i].st));
            expect_eq($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(tbl[i].err));
            idle(2);
        end

        // Foreign packet type is dropped silently, then a doubled '!' resyncs
        tick(1, 8'h21); tick(1, 8'h51); tick(1, 8'h01); tick(1, 8'h02);
        idle(1);
        expect_eq("foreign_err", 32'(err_cnt), 32'd3);
        tick(1, 8'h21);
        send5(40'h2142383133);
        tick(0, 0);
        expect_eq("resync_evt", {ev, ev_btn, ev_pr}, {1'b1, 3'd7, 1'b1});
        expect_eq("resync_state", 32'(btn_state), 32'h80);

        // Stall of a full timeout window aborts; trailing bytes ignored until '!'
        tick(1, 8'h21); tick(1, 8'h42);
        idle(TO);
        tick(1, 8'h33); tick(1, 8'h31); tick(1, 8'h36);
        tick(0, 0);
        expect_eq("timeout_err", 32'(err_cnt), 32'd4);
        expect_eq("timeout_no_ev", 32'(ev), 32'd0);

        tick(1, 8'h21); tick(1, 8'h42);
        idle(TO - 2);
        tick(1, 8'h35); tick(1, 8'h31); tick(1, 8'h36);
        tick(0, 0);
        expect_eq("short_gap_ev", {ev, ev_btn, ev_pr}, {1'b1, 3'd4, 1'b1});
        expect_eq("short_gap_state", 32'(btn_state), 32'h90);

        // Byte on the expiry cycle itself keeps the packet alive
        tick(1, 8'h21); tick(1, 8'h42);
        idle(TO - 1);
        tick(1, 8'h35); tick(1, 8'h30); tick(1, 8'h37);
        tick(0, 0);
        expect_eq("edge_gap_ev", {ev, ev_btn, ev_pr}, {1'b1, 3'd4, 1'b0});
        expect_eq("edge_gap_err", 32'(err_cnt), 32'd4);

        repeat (300) send5(40'h2142313100);
        tick(0, 0);
        expect_eq("err_saturate", 32'(err_cnt), 32'hFF);

        for (int it = 0; it < 800; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                p[0] = 8'h21; p[1] = 8'h42;
                p[2] = 8'(8'h31 + $urandom_range(0, 7));
                p[3] = 8'(8'h30 + $urandom_range(0, 1));
                s = p[0] + p[1] + p[2] + p[3];
                p[4] = ~s;
                if ($urandom_range(0, 3) == 0) p[$urandom_range(0, 4)] ^= 8'(1 << $urandom_range(0, 7));
                for (int k = 0; k < 5; k++) begin
                    tick(1, p[k]);
                    idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 3));
                end
            end else if (r == 6) begin
                repeat ($urandom_range(1, 4)) tick(1, 8'($urandom));
            end else if (r == 7) begin
                tick(1, 8'h21); tick(1, 8'h42);
                idle(TO - 2 + $urandom_range(0, 3));
            end else if (r == 8) begin
                tick(1, 8'h21);
                idle(TO - 1);
                tick(1, 8'h42);
            end else begin
                idle($urandom_range(1, 5));
            end
        end
        idle(TO + 2);

        // Asynchronous reset in the middle of a packet
        send5(40'h2142353136);
        tick(1, 8'h21); tick(1, 8'h42); tick(1, 8'h36);
        tick(0, 0);
        #2 rst = 1'b1;
        #1;
        expect_eq("reset_mid_pkt", {19'd0, ev, ev_btn, ev_pr, btn_state, err_cnt}, 32'd0);
        model_reset();
        #1 rst = 1'b0;
        send5(40'h2142353136);
        tick(0, 0);
        expect_eq("post_reset_evt", {ev, ev_btn, ev_pr}, {1'b1, 3'd4, 1'b1});
        expect_eq("post_reset_state", {btn_state, err_cnt}, {8'h10, 8'h00});
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
